// File: rtl/g_buffer_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : g_buffer_arbiter_if
// Description : Bundle of the requester-side handshakes (vertex write,
//               triangle read request, triangle output) and the g_buffer
//               access port seen by g_buffer_arbiter.
//               slave  : arbiter view (drives grants, triangle output and
//                        g_buffer controls).
//               master : environment view (requesters, consumer, g_buffer).
// Revision    : 1.0 - initial release
// ============================================================================
interface g_buffer_arbiter_if #(
  parameter int VERTEX_DATAWIDTH = 12,
  parameter int MAX_NUM_VERTEXES = 1024
);
  localparam int c_vw = 3 * VERTEX_DATAWIDTH;
  localparam int c_aw = $clog2(MAX_NUM_VERTEXES);

  // vertex write channel
  logic            wr_valid;
  logic            wr_ready;
  logic [c_aw-1:0] wr_addr;
  logic [c_vw-1:0] wr_data;
  // triangle read request channel
  logic            rd_valid;
  logic            rd_ready;
  logic [c_aw-1:0] rd_idx0;
  logic [c_aw-1:0] rd_idx1;
  logic [c_aw-1:0] rd_idx2;
  // triangle output channel
  logic            tri_valid;
  logic            tri_ready;
  logic [c_vw-1:0] tri_v0;
  logic [c_vw-1:0] tri_v1;
  logic [c_vw-1:0] tri_v2;
  // g_buffer access port
  logic            gb_ready;
  logic            gb_en;
  logic            gb_rw;
  logic [c_aw-1:0] gb_addr_write;
  logic [c_aw-1:0] gb_addr_read0;
  logic [c_aw-1:0] gb_addr_read1;
  logic [c_aw-1:0] gb_addr_read2;
  logic [c_vw-1:0] gb_data_write;
  logic [c_vw-1:0] gb_data_read0;
  logic [c_vw-1:0] gb_data_read1;
  logic [c_vw-1:0] gb_data_read2;
  logic            gb_dv;

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    input  rd_valid, rd_idx0, rd_idx1, rd_idx2,
    input  tri_ready,
    input  gb_ready, gb_data_read0, gb_data_read1, gb_data_read2, gb_dv,
    output wr_ready, rd_ready,
    output tri_valid, tri_v0, tri_v1, tri_v2,
    output gb_en, gb_rw, gb_addr_write, gb_addr_read0, gb_addr_read1,
    output gb_addr_read2, gb_data_write
  );

  modport master (
    output wr_valid, wr_addr, wr_data,
    output rd_valid, rd_idx0, rd_idx1, rd_idx2,
    output tri_ready,
    output gb_ready, gb_data_read0, gb_data_read1, gb_data_read2, gb_dv,
    input  wr_ready, rd_ready,
    input  tri_valid, tri_v0, tri_v1, tri_v2,
    input  gb_en, gb_rw, gb_addr_write, gb_addr_read0, gb_addr_read1,
    input  gb_addr_read2, gb_data_write
  );
endinterface
`default_nettype wire

// File: rtl/g_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : g_buffer_arbiter
// Description : Shares the single g_buffer access port between the vertex
//               writer and the triangle reader. Round-robin arbitration,
//               per-frame vertex-count scoreboard gating triangle reads, and
//               a held triangle output under valid/ready backpressure.
// Ports       : clk, rstn (async active-low), frame_start (clears count),
//               vert_count (vertices written this frame),
//               bus (g_buffer_arbiter_if.slave: wr/rd/tri channels + g_buffer)
// Revision    : 1.0 - initial release
// ============================================================================
module g_buffer_arbiter #(
  parameter int VERTEX_DATAWIDTH = 12,
  parameter int MAX_NUM_VERTEXES = 1024
) (
  input  wire logic                               clk,
  input  wire logic                               rstn,
  input  wire logic                               frame_start,
  output      logic [$clog2(MAX_NUM_VERTEXES):0]  vert_count,
  g_buffer_arbiter_if.slave                       bus
);
  localparam int c_vw = 3 * VERTEX_DATAWIDTH;
  localparam int c_aw = $clog2(MAX_NUM_VERTEXES);
  localparam logic [c_aw:0] c_max_count = (c_aw+1)'(MAX_NUM_VERTEXES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_OUT     = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_last_read;   // 1: previous grant went to the reader
  logic            r_gb_en_d;     // an access was issued last cycle
  logic [c_aw-1:0] r_idx0, r_idx1, r_idx2;
  logic [c_vw-1:0] r_tri_v0, r_tri_v1, r_tri_v2;
  logic            r_tri_valid;
  logic [c_aw:0]   r_vert_count;

  logic            w_can_grant;
  logic            w_wr_elig;
  logic            w_rd_elig;
  logic            w_grant_wr;
  logic            w_grant_rd;

  // Back-to-back accesses are suppressed so gb_en never stays high for two
  // cycles; the g_buffer needs a gap to update its ready status.
  assign w_can_grant = bus.gb_ready && !r_gb_en_d;
  assign w_wr_elig   = bus.wr_valid && (r_state != S_RD_WAIT);
  // A triangle is readable only once all three vertices exist this frame.
  assign w_rd_elig   = bus.rd_valid && (r_state == S_IDLE) &&
                       ({1'b0, bus.rd_idx0} < r_vert_count) &&
                       ({1'b0, bus.rd_idx1} < r_vert_count) &&
                       ({1'b0, bus.rd_idx2} < r_vert_count);

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Arbitration and next-state
  always_comb begin
    w_state_nxt = r_state;
    w_grant_wr  = 1'b0;
    w_grant_rd  = 1'b0;
    if (w_can_grant) begin
      if (w_wr_elig && w_rd_elig) begin
        w_grant_wr = r_last_read;
        w_grant_rd = !r_last_read;
      end else begin
        w_grant_wr = w_wr_elig;
        w_grant_rd = w_rd_elig;
      end
    end
    case (r_state)
      S_IDLE:    if (w_grant_rd)    w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: if (bus.gb_dv)     w_state_nxt = S_OUT;
      S_OUT:     if (bus.tri_ready) w_state_nxt = S_IDLE;
      default:                      w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: grant history, index latches, triangle hold, scoreboard
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last_read  <= 1'b1;
      r_gb_en_d    <= 1'b0;
      r_idx0       <= '0;
      r_idx1       <= '0;
      r_idx2       <= '0;
      r_tri_v0     <= '0;
      r_tri_v1     <= '0;
      r_tri_v2     <= '0;
      r_tri_valid  <= 1'b0;
      r_vert_count <= '0;
    end else begin
      r_gb_en_d <= w_grant_wr || w_grant_rd;
      if (w_grant_wr) begin
        r_last_read <= 1'b0;
      end else if (w_grant_rd) begin
        r_last_read <= 1'b1;
      end
      if (w_grant_rd) begin
        r_idx0 <= bus.rd_idx0;
        r_idx1 <= bus.rd_idx1;
        r_idx2 <= bus.rd_idx2;
      end
      // Data valid is only meaningful while a read is outstanding.
      if (r_state == S_RD_WAIT && bus.gb_dv) begin
        r_tri_v0    <= bus.gb_data_read0;
        r_tri_v1    <= bus.gb_data_read1;
        r_tri_v2    <= bus.gb_data_read2;
        r_tri_valid <= 1'b1;
      end else if (r_state == S_OUT && bus.tri_ready) begin
        r_tri_valid <= 1'b0;
      end
      // A new frame wins over a coincident write; the write still goes out.
      if (frame_start) begin
        r_vert_count <= '0;
      end else if (w_grant_wr && r_vert_count < c_max_count) begin
        r_vert_count <= r_vert_count + 1'b1;
      end
    end
  end

  assign bus.gb_en         = w_grant_wr || w_grant_rd;
  assign bus.gb_rw         = w_grant_wr;
  assign bus.wr_ready      = w_grant_wr;
  assign bus.rd_ready      = w_grant_rd;
  assign bus.gb_addr_write = bus.wr_addr;
  assign bus.gb_data_write = bus.wr_data;
  assign bus.gb_addr_read0 = w_grant_rd ? bus.rd_idx0 : r_idx0;
  assign bus.gb_addr_read1 = w_grant_rd ? bus.rd_idx1 : r_idx1;
  assign bus.gb_addr_read2 = w_grant_rd ? bus.rd_idx2 : r_idx2;
  assign bus.tri_valid     = r_tri_valid;
  assign bus.tri_v0        = r_tri_v0;
  assign bus.tri_v1        = r_tri_v1;
  assign bus.tri_v2        = r_tri_v2;
  assign vert_count        = r_vert_count;
endmodule
`default_nettype wire

// File: tb/tb_g_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_g_buffer_arbiter
// Description : Self-checking bench for g_buffer_arbiter. A g_buffer model
//               answers reads four cycles after the grant; a cycle model of
//               the arbitration rules is checked against the DUT each cycle,
//               and directed scenarios pin literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_g_buffer_arbiter;
  localparam int VDW  = 12;
  localparam int MAXV = 1024;
  localparam int VW   = 3 * VDW;
  localparam int AW   = $clog2(MAXV);

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          frame_start = 1'b0;
  logic [AW:0]   vert_count;
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;

  g_buffer_arbiter_if #(.VERTEX_DATAWIDTH(VDW), .MAX_NUM_VERTEXES(MAXV)) bus ();

  g_buffer_arbiter #(.VERTEX_DATAWIDTH(VDW), .MAX_NUM_VERTEXES(MAXV)) dut (
    .clk(clk), .rstn(rstn), .frame_start(frame_start),
    .vert_count(vert_count), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- g_buffer model ----------------
  logic [VW-1:0] mem [0:MAXV-1];
  logic [VW-1:0] rd_d0, rd_d1, rd_d2;
  int            dv_at = -1;

  initial begin
    forever begin
      @(negedge clk);
      if (bus.gb_en === 1'b1) begin
        if (bus.gb_rw) begin
          mem[bus.gb_addr_write] = bus.gb_data_write;
        end else begin
          dv_at = cyc + 4;
          rd_d0 = mem[bus.gb_addr_read0];
          rd_d1 = mem[bus.gb_addr_read1];
          rd_d2 = mem[bus.gb_addr_read2];
        end
      end
    end
  end

  initial begin
    bus.gb_dv = 1'b0;
    bus.gb_data_read0 = '0;
    bus.gb_data_read1 = '0;
    bus.gb_data_read2 = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.gb_dv = (cyc == dv_at);
      bus.gb_data_read0 = (cyc == dv_at) ? rd_d0 : '0;
      bus.gb_data_read1 = (cyc == dv_at) ? rd_d1 : '0;
      bus.gb_data_read2 = (cyc == dv_at) ? rd_d2 : '0;
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  initial begin
    int            m_vc;
    bit            m_last_read, m_prev_en, m_tvalid;
    int            m_phase;   // 0 free, 1 read outstanding, 2 triangle held
    logic [AW-1:0] m_idx [3];
    logic [VW-1:0] m_tv [3];
    bit            can, wr_el, rd_el, gw, gr;
    logic [AW-1:0] exp_a0, exp_a1, exp_a2;
    m_vc = 0; m_last_read = 1'b1; m_prev_en = 1'b0; m_tvalid = 1'b0; m_phase = 0;
    for (int i = 0; i < 3; i++) begin m_idx[i] = '0; m_tv[i] = '0; end
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!rstn) begin
        m_vc = 0; m_last_read = 1'b1; m_prev_en = 1'b0; m_tvalid = 1'b0; m_phase = 0;
        for (int i = 0; i < 3; i++) begin m_idx[i] = '0; m_tv[i] = '0; end
        check("rst_tri_valid", bus.tri_valid, 0);
        check("rst_vert_count", vert_count, 0);
        check("rst_tri_v0", bus.tri_v0, 0);
        check("rst_tri_v2", bus.tri_v2, 0);
      end else begin
        can   = bus.gb_ready && !m_prev_en;
        wr_el = bus.wr_valid && (m_phase != 1);
        rd_el = bus.rd_valid && (m_phase == 0) && (int'(bus.rd_idx0) < m_vc) &&
                (int'(bus.rd_idx1) < m_vc) && (int'(bus.rd_idx2) < m_vc);
        gw = 1'b0; gr = 1'b0;
        if (can) begin
          if (wr_el && rd_el) begin
            gw = m_last_read;       // whoever did not win last time
            gr = !m_last_read;
          end else begin
            gw = wr_el;
            gr = rd_el;
          end
        end
        exp_a0 = gr ? bus.rd_idx0 : m_idx[0];
        exp_a1 = gr ? bus.rd_idx1 : m_idx[1];
        exp_a2 = gr ? bus.rd_idx2 : m_idx[2];
        check("m_wr_ready", bus.wr_ready, gw);
        check("m_rd_ready", bus.rd_ready, gr);
        check("m_gb_en", bus.gb_en, gw | gr);
        check("m_gb_rw", bus.gb_rw, gw);
        check("m_tri_valid", bus.tri_valid, m_tvalid);
        check("m_tri_v0", bus.tri_v0, m_tv[0]);
        check("m_tri_v1", bus.tri_v1, m_tv[1]);
        check("m_tri_v2", bus.tri_v2, m_tv[2]);
        check("m_vert_count", vert_count, m_vc);
        check("m_gb_addr_read0", bus.gb_addr_read0, exp_a0);
        check("m_gb_addr_read1", bus.gb_addr_read1, exp_a1);
        check("m_gb_addr_read2", bus.gb_addr_read2, exp_a2);
        if (gw) begin
          check("m_gb_addr_write", bus.gb_addr_write, bus.wr_addr);
          check("m_gb_data_write", bus.gb_data_write, bus.wr_data);
        end
        m_prev_en = gw | gr;
        if (gw) m_last_read = 1'b0;
        if (gr) begin
          m_last_read = 1'b1;
          m_idx[0] = bus.rd_idx0; m_idx[1] = bus.rd_idx1; m_idx[2] = bus.rd_idx2;
          m_phase = 1;
        end else if (m_phase == 1 && bus.gb_dv) begin
          m_tv[0] = bus.gb_data_read0; m_tv[1] = bus.gb_data_read1; m_tv[2] = bus.gb_data_read2;
          m_tvalid = 1'b1;
          m_phase = 2;
        end else if (m_phase == 2 && bus.tri_ready) begin
          m_tvalid = 1'b0;
          m_phase = 0;
        end
        if (frame_start) m_vc = 0;
        else if (gw && m_vc < MAXV) m_vc++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_write(input logic [AW-1:0] a, input logic [VW-1:0] d, output int gc);
    gc = -1;
    bus.wr_valid = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    for (int i = 0; i < 40 && gc < 0; i++) begin
      @(negedge clk);
      if (bus.wr_ready) gc = cyc;
      tick();
    end
    bus.wr_valid = 1'b0;
    check("write_granted", gc >= 0, 1);
  endtask

  // Returns at the negedge of the first tri_valid cycle.
  task automatic do_read(input logic [AW-1:0] i0, input logic [AW-1:0] i1,
                         input logic [AW-1:0] i2, output int gc, output int lat);
    gc = -1; lat = -1;
    bus.rd_valid = 1'b1; bus.rd_idx0 = i0; bus.rd_idx1 = i1; bus.rd_idx2 = i2;
    for (int i = 0; i < 60 && gc < 0; i++) begin
      @(negedge clk);
      if (bus.rd_ready) gc = cyc;
      tick();
    end
    bus.rd_valid = 1'b0;
    check("read_granted", gc >= 0, 1);
    if (gc >= 0) begin
      for (int i = 0; i < 20 && lat < 0; i++) begin
        @(negedge clk);
        if (bus.tri_valid) lat = cyc - gc;
        else tick();
      end
    end
    check("tri_valid_seen", lat >= 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int gc, wgc, rgc, lat, vc0, nwait;
    bit done, stable;
    logic [VW-1:0] h0, h1, h2;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_valid = 1'b0; bus.rd_idx0 = '0; bus.rd_idx1 = '0; bus.rd_idx2 = '0;
    bus.tri_ready = 1'b0; bus.gb_ready = 1'b1;
    rstn = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_tri_valid", bus.tri_valid, 0);
    check("reset_vert_count", vert_count, 0);
    tick();
    rstn = 1'b1;
    tick();

    // 1: three writes then one triangle read
    bus.tri_ready = 1'b1;
    do_write(10'd0, 36'h001002003, gc);
    do_write(10'd1, 36'h004005006, gc);
    do_write(10'd2, 36'h007008009, gc);
    @(negedge clk);
    check("t1_vert_count", vert_count, 3);
    tick();
    do_read(10'd0, 10'd1, 10'd2, gc, lat);
    check("t1_latency", lat, 5);
    check("t1_tri_v0", bus.tri_v0, 36'h001002003);
    check("t1_tri_v1", bus.tri_v1, 36'h004005006);
    check("t1_tri_v2", bus.tri_v2, 36'h007008009);
    tick();

    // 2: read waits on the scoreboard until vertex 5 exists
    bus.rd_valid = 1'b1; bus.rd_idx0 = 10'd0; bus.rd_idx1 = 10'd1; bus.rd_idx2 = 10'd5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_blocked_rd_ready", bus.rd_ready, 0);
      tick();
    end
    do_write(10'd3, 36'h00100200A, gc);
    do_write(10'd4, 36'h00300400B, gc);
    do_write(10'd5, 36'h00500600C, wgc);
    do_read(10'd0, 10'd1, 10'd5, rgc, lat);
    check("t2_read_after_count", rgc - wgc, 2);
    check("t2_latency", lat, 5);
    check("t2_tri_v1", bus.tri_v1, 36'h004005006);
    check("t2_tri_v2", bus.tri_v2, 36'h00500600C);
    tick();

    // 3: simultaneous eligible requests with last grant = read
    bus.tri_ready = 1'b0;
    bus.wr_valid = 1'b1; bus.wr_addr = 10'd6; bus.wr_data = 36'h00A00B00C;
    bus.rd_valid = 1'b1; bus.rd_idx0 = 10'd0; bus.rd_idx1 = 10'd1; bus.rd_idx2 = 10'd2;
    wgc = -1; rgc = -1; nwait = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.tri_valid) done = 1'b1;
      else begin
        if (bus.wr_ready) begin
          if (wgc < 0) wgc = cyc;
          else if (rgc >= 0) nwait++;
        end
        if (bus.rd_ready) rgc = cyc;
      end
      tick();
      if (wgc >= 0) begin bus.wr_addr = 10'd7; bus.wr_data = 36'h00D00E00F; end
      if (rgc >= 0) bus.rd_valid = 1'b0;
    end
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b0;
    check("t3_done", done, 1);
    check("t3_write_first", wgc >= 0, 1);
    check("t3_read_after_write", rgc - wgc, 2);
    check("t3_no_write_in_rd_wait", nwait, 0);

    // 4: triangle held under backpressure while two writes proceed
    h0 = '0; h1 = '0; h2 = '0; vc0 = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 1 || k == 5) begin
        bus.wr_valid = 1'b1; bus.wr_addr = 10'(8 + k); bus.wr_data = 36'(k);
      end
      @(negedge clk);
      if (k == 0) begin
        h0 = bus.tri_v0; h1 = bus.tri_v1; h2 = bus.tri_v2; vc0 = int'(vert_count);
        check("t4_held_v0", h0, 36'h001002003);
      end
      stable = (bus.tri_v0 == h0) && (bus.tri_v1 == h1) && (bus.tri_v2 == h2);
      check("t4_tri_stable", stable, 1);
      check("t4_tri_valid", bus.tri_valid, 1);
      if (k == 1 || k == 5) check("t4_write_in_out", bus.wr_ready, 1);
      tick();
      bus.wr_valid = 1'b0;
    end
    @(negedge clk);
    check("t4_vert_count_plus2", vert_count, vc0 + 2);
    tick();
    bus.tri_ready = 1'b1;
    @(negedge clk);
    check("t4_valid_before_accept", bus.tri_valid, 1);
    tick();
    bus.tri_ready = 1'b0;
    @(negedge clk);
    check("t4_valid_after_accept", bus.tri_valid, 0);
    tick();

    // 5: gb_ready gating, then frame_start coincident with a write
    bus.gb_ready = 1'b0;
    bus.wr_valid = 1'b1; bus.wr_addr = 10'd20; bus.wr_data = 36'h0000000AA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_no_grant_busy", bus.wr_ready, 0);
      tick();
    end
    bus.gb_ready = 1'b1;
    @(negedge clk);
    check("t5_grant_when_ready", bus.wr_ready, 1);
    tick();
    bus.wr_valid = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    @(negedge clk);
    check("t5_frame_clear", vert_count, 0);
    tick();
    for (int i = 0; i < 7; i++) do_write(10'(i), 36'h100 + 36'(i), gc);
    @(negedge clk);
    check("t5_count7", vert_count, 7);
    tick();
    bus.wr_valid = 1'b1; bus.wr_addr = 10'd9; bus.wr_data = 36'hABCDEF012;
    frame_start = 1'b1;
    @(negedge clk);
    check("t5_fs_write_grant", bus.wr_ready, 1);
    check("t5_fs_gb_rw", bus.gb_rw, 1);
    tick();
    frame_start = 1'b0;
    bus.wr_valid = 1'b0;
    @(negedge clk);
    check("t5_fs_priority", vert_count, 0);
    check("t5_fs_write_issued", mem[9], 36'hABCDEF012);
    tick();

    // 6: reset two cycles after a read grant discards the read
    bus.tri_ready = 1'b1;
    do_write(10'd0, 36'h001002003, gc);
    do_write(10'd1, 36'h004005006, gc);
    do_write(10'd2, 36'h007008009, gc);
    bus.rd_valid = 1'b1; bus.rd_idx0 = 10'd0; bus.rd_idx1 = 10'd1; bus.rd_idx2 = 10'd2;
    rgc = -1;
    for (int i = 0; i < 40 && rgc < 0; i++) begin
      @(negedge clk);
      if (bus.rd_ready) rgc = cyc;
      tick();
    end
    bus.rd_valid = 1'b0;
    check("t6_read_granted", rgc >= 0, 1);
    tick();
    rstn = 1'b0;
    #1;
    check("t6_async_tri_valid", bus.tri_valid, 0);
    check("t6_async_vert_count", vert_count, 0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("t6_no_stale_tri_valid", bus.tri_valid, 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
